// File: rtl/aes_pkg.sv
// Shared AES decrypt definitions: inverse S-box, GF(2^8) helpers, round-count and FSM types.
// Latency: none, purely combinational functions and constants.
// Backpressure: none; used only by the round logic and the control FSM.
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } st_e;

    // Byte x of the inverse S-box lives at INV_SBOX[8*x +: 8] (ascending range, entry 0 leftmost).
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{x, 3'b000} +: 8];
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Small-coefficient multiply; InvMixColumns only needs 4-bit constants.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Unsupported round counts fall back to AES-128.
    function automatic logic [3:0] nr_norm(input logic [3:0] nr);
        case (nr)
            NR_192:  return NR_192;
            NR_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [0:127] rk_slice(input logic [0:1919] w, input logic [3:0] i);
        return w[{i, 7'd0} +: 128];
    endfunction

endpackage

// File: rtl/inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module inv_round
    import aes_pkg::*;
(
    input  logic [0:127] state_i,
    input  logic [0:127] rk_i,
    input  logic         last_i,
    output logic [0:127] state_o
);

    logic [0:127] added;
    logic [0:127] mixed;

    // Column byte order a0..a3 is rows 0..3 of one state column.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // Row r is rotated right by r: output column c takes input column (c - r) mod 4.
    always_comb begin
        added = '0;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                added[8*(4*c+r) +: 8] = inv_sbox(state_i[8*(4*((c+4-r)%4)+r) +: 8])
                                        ^ rk_i[8*(4*c+r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = inv_mix_col(added[32*c +: 32]);
        end
    end

    assign state_o = last_i ? added : mixed;

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128/192/256 block decryptor, one inverse round per clock from a flat key schedule.
// Latency: Nr+1 clocks from the start edge (11/13/15) to flag and plaintext.
// Backpressure: cs must stay high through completion; dropping it aborts, result held while it stays high.
module inv_cipher
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [0:3]    Nr,
    input  logic [0:127]  init,
    input  logic [0:1919] w,
    output logic [0:127]  Decrypted_Msg,
    output logic          flag
);

    st_e          st_q, st_d;
    logic [0:127] state_q, state_d;
    logic [0:127] msg_q, msg_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         flag_q, flag_d;

    logic [3:0]   nr_eff;
    logic [3:0]   rk_idx;
    logic [0:127] rk;
    logic [0:127] round_out;
    logic         last_rnd;

    // At start the key for the initial AddRoundKey is rk[Nr]; afterwards the counter selects it.
    assign nr_eff   = nr_norm(Nr);
    assign rk_idx   = (st_q == ST_IDLE) ? nr_eff : rnd_q;
    assign rk       = rk_slice(w, rk_idx);
    assign last_rnd = (rnd_q == 4'd0);

    inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk),
        .last_i  (last_rnd),
        .state_o (round_out)
    );

    // Next-state, round stepping and result capture.
    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        msg_d   = msg_q;
        flag_d  = flag_q;
        case (st_q)
            ST_IDLE: begin
                flag_d = 1'b0;
                if (cs) begin
                    state_d = init ^ rk;
                    rnd_d   = nr_eff - 4'd1;
                    st_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (!cs) begin
                    flag_d = 1'b0;
                    st_d   = ST_IDLE;
                end else if (last_rnd) begin
                    msg_d  = round_out;
                    flag_d = 1'b1;
                    st_d   = ST_DONE;
                end else begin
                    state_d = round_out;
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!cs) begin
                    flag_d = 1'b0;
                    st_d   = ST_IDLE;
                end else begin
                    flag_d = 1'b1;
                end
            end
            default: begin
                flag_d = 1'b0;
                st_d   = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            state_q <= '0;
            msg_q   <= '0;
            rnd_q   <= 4'd0;
            flag_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            msg_q   <= msg_d;
            rnd_q   <= rnd_d;
            flag_q  <= flag_d;
        end
    end

    assign Decrypted_Msg = msg_q;
    assign flag          = flag_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors plus random blocks encrypted by a forward-AES reference model.
// Latency: checks flag rises exactly Nr+1 edges after the start edge.
// Backpressure: exercises abort, reset in ROUND/DONE and back-to-back blocks.
module tb_inv_cipher;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic [0:3]    Nr;
    logic [0:127]  init;
    logic [0:1919] w;
    logic [0:127]  Decrypted_Msg;
    logic          flag;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0]  sb[256];
    logic [31:0] wk[60];

    inv_cipher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cs            (cs),
        .Nr            (Nr),
        .init          (init),
        .w             (w),
        .Decrypted_Msg (Decrypted_Msg),
        .flag          (flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout passed=%0d total=%0d", n_pass, n_tot);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- reference model (forward AES) ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key schedule into the flat bus; unused tail words are random so a bad key index shows up.
    task automatic expand_key(input logic [0:255] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 60; i++) w[32*i +: 32] = $urandom;
        for (int i = 0; i < nk; i++) wk[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = wk[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = m_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wk[i] = wk[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) w[32*i +: 32] = wk[i];
    endtask

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input int nr);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[8*i +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = m_mul(t[4*c],2) ^ m_mul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ m_mul(t[4*c+1],2) ^ m_mul(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(t[4*c+2],2) ^ m_mul(t[4*c+3],3);
                    s[4*c+3] = m_mul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(t[4*c+3],2);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[128*r + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called just after a negedge; leaves cs low for exactly one sampled edge on return.
    task automatic run_block(input logic [0:127] ct, input logic [3:0] nr_in,
                             input logic [0:127] exp, input string tag);
        int eff;
        int edges;
        eff   = (nr_in == 4'd12 || nr_in == 4'd14) ? int'(nr_in) : 10;
        init  = ct;
        Nr    = nr_in;
        cs    = 1'b1;
        edges = 0;
        while (edges < 20) begin
            @(negedge clk);
            edges++;
            if (flag) break;
        end
        check({tag, " latency"}, 128'(edges), 128'(eff + 1));
        check({tag, " result"}, Decrypted_Msg, exp);
        @(negedge clk);
        check({tag, " flag_hold"}, 128'(flag), 128'(1));
        cs = 1'b0;
        @(negedge clk);
        check({tag, " flag_clear"}, 128'(flag), 128'(0));
        check({tag, " msg_kept"}, Decrypted_Msg, exp);
    endtask

    localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;

    logic [0:255] key;
    logic [0:127] pt, ct, prior;
    int           sel, nk, nr, edges;

    initial begin
        build_sbox();
        rst_n = 1'b0;
        cs    = 1'b0;
        Nr    = 4'd10;
        init  = '0;
        w     = '0;
        repeat (2) @(negedge clk);
        check("reset flag", 128'(flag), 128'(0));
        check("reset msg", Decrypted_Msg, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 vectors, back-to-back with one cs-low edge between them.
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        run_block(128'h3925841d02dc09fbdc118597196a0b32, 4'd10,
                  128'h3243f6a8885a308d313198a2e0370734, "fips_b");
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10, PT_C, "fips_c1");
        expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
        run_block(128'hdda97ca4864cdfe06eaf70a0ec0d7191, 4'd12, PT_C, "fips_c2");
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        run_block(128'h8ea2b7ca516745bfeafc49904b496089, 4'd14, PT_C, "fips_c3");

        // Abort after five rounds: no flag, previous result kept, then a clean restart.
        prior = PT_C;
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
        expand_key(key, 4, 10);
        ct   = encrypt(pt, 10);
        init = ct;
        Nr   = 4'd10;
        cs   = 1'b1;
        repeat (6) @(negedge clk);
        check("abort mid flag", 128'(flag), 128'(0));
        cs = 1'b0;
        @(negedge clk);
        check("abort flag", 128'(flag), 128'(0));
        check("abort msg", Decrypted_Msg, prior);
        @(negedge clk);
        check("abort idle msg", Decrypted_Msg, prior);
        run_block(ct, 4'd10, pt, "restart");

        // Unsupported Nr behaves as 10.
        for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
        ct = encrypt(pt, 10);
        run_block(ct, 4'd11, pt, "nr_invalid");

        // Random keys and blocks across all three key sizes.
        for (int n = 0; n < 6; n++) begin
            sel = $urandom_range(0, 2);
            nk  = 4 + 2*sel;
            nr  = nk + 6;
            for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
            for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
            expand_key(key, nk, nr);
            ct = encrypt(pt, nr);
            run_block(ct, 4'(nr), pt, $sformatf("rand%0d_nr%0d", n, nr));
        end

        // Reset during ROUND clears everything; the block after it runs from IDLE.
        init = ct;
        Nr   = 4'(nr);
        cs   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_round flag", 128'(flag), 128'(0));
        check("rst_round msg", Decrypted_Msg, 128'h0);
        cs    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_block(ct, 4'(nr), pt, "after_rst_round");

        // Reset during DONE with cs still high.
        init  = ct;
        Nr    = 4'(nr);
        cs    = 1'b1;
        edges = 0;
        while (edges < 20) begin
            @(negedge clk);
            edges++;
            if (flag) break;
        end
        check("pre_rst_done result", Decrypted_Msg, pt);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_done flag", 128'(flag), 128'(0));
        check("rst_done msg", Decrypted_Msg, 128'h0);
        cs    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done idle flag", 128'(flag), 128'(0));
        run_block(ct, 4'(nr), pt, "after_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
